id_ex_hazard_reg: RTL and testbench
===================================

// Module: id_ex_hazard_reg
// PURPOSE
//   ID/EX pipeline register with integrated load-use and branch-operand hazard detection.
//   Latches decoded ID-stage fields into the ID_EX_* signals consumed by the forwarding unit
//   and the EX stage. Stalls PC and IF/ID and injects bubbles when forwarding cannot cover a hazard.
//   Sits between the decoder/register file (ID) and the EX-stage operand muxes.
// PARAMETERS
//   REG_ADDR_WIDTH  `REG_ADDR_WIDTH (5)  register index width
//   DATA_WIDTH      32                   operand / immediate / PC width
//   ALU_OP_WIDTH    4                    ALU control field width
//   BRANCH_OPCODE   7'b1100011           branch opcode; equals the forwarding unit's branch decode
// PORTS
//   clk              in   1    clock, rising edge
//   rst_n            in   1    asynchronous active-low reset
//   flush            in   1    kill ID-stage instruction (redirect)
//   hold             in   1    global freeze (e.g. memory wait)
//   id_valid         in   1    ID instruction valid
//   id_opcode        in   7    ID opcode
//   id_rs1/id_rs2    in   RAW  source register indices, each REG_ADDR_WIDTH
//   id_rd            in   RAW  destination register index
//   id_rs1_data/id_rs2_data/id_imm/id_pc  in  DW  operands, immediate, PC
//   id_reg_wr_en/id_mem_rd_en/id_mem_wr_en  in  1  control bits
//   id_alu_op        in   AOW  ALU control
//   EX_MEM_mem_rd_en in   1    load currently in MEM
//   EX_MEM_rd        in   RAW  its destination
//   ID_EX_*          out  -    registered copies of every id_* field above (same widths), incl. ID_EX_valid
//   stall            out  1    1 = hold PC and IF/ID this cycle
// BEHAVIOUR
//   Reset: all ID_EX_* = 0 (ID_EX_valid = 0), FSM = RUN, stall_cnt = 0, stall = 0.
//   uses_rs2 = opcode in {0110011, 0100011, BRANCH_OPCODE}; is_br = (id_opcode == BRANCH_OPCODE).
//   Hazards (combinational, only when id_valid):
//     lu  = ID_EX_mem_rd_en & ID_EX_rd!=0 & (ID_EX_rd==id_rs1 | uses_rs2 & ID_EX_rd==id_rs2)
//     bm  = is_br & EX_MEM_mem_rd_en & EX_MEM_rd!=0 & (EX_MEM_rd==id_rs1 | EX_MEM_rd==id_rs2)
//     bl2 = is_br & lu   (load in EX feeding branch in ID: 2 bubbles)
//   FSM RUN/STALL, 1-bit stall_cnt:
//     RUN:   bl2 -> STALL, cnt=1 ; (lu|bm) & !bl2 -> stay RUN (1 bubble) ; else RUN
//     STALL: cnt==1 -> cnt=0, RUN next cycle ; hazard inputs ignored while in STALL
//   stall = (RUN & (lu|bm)) | STALL; combinational from registered state + ID inputs, 0 latency.
//   Each edge, priority: flush > hold > stall > load.
//     flush: ID_EX gets bubble, FSM -> RUN, cnt -> 0; stall = 0 in the flush cycle.
//     hold (no flush): all registers and FSM frozen; stall output keeps its value.
//     stall: ID_EX gets bubble.
//     else: ID_EX_* <= id_*, ID_EX_valid <= id_valid.
//   Bubble: valid, reg_wr_en, mem_rd_en, mem_wr_en = 0; rd/rs1/rs2 = 0; data fields don't care (drive 0).
//   id_valid = 0 loads a bubble and raises no hazard.
//   Index 0 never triggers a hazard.
//   Simultaneous lu & bm: one bubble, unless bl2.
//   Reset mid-stall: immediate return to reset state.
// TESTING
//   lw x5 in EX; add x6,x5,x7 in ID -> stall=1 one cycle, one bubble, add enters ID_EX next cycle.
//   lw x5 in EX; beq x5,x0 in ID -> stall=1 two cycles (FSM RUN->STALL->RUN), two bubbles, beq latched cycle 3.
//   lw x5 in MEM (EX_MEM_rd=5); beq x1,x5 in ID -> single-cycle stall, one bubble.
//   lw x0 in EX; add x1,x0,x0 -> no stall; I-type addi x1,x5 with lw in EX writing x5 via rs2 slot only -> no stall.
//   flush asserted during STALL -> bubble, state RUN, stall=0 that cycle; hold=1 for 3 cycles -> ID_EX_* unchanged.
//   rst_n pulsed low mid-STALL (async, between edges) -> all outputs 0 immediately; normal load resumes after release.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use and branch-operand hazard detection.
// Stalls PC/IF-ID and injects bubbles when forwarding cannot cover a hazard.
module id_ex_hazard_reg #(
    parameter int          REG_ADDR_WIDTH = 5,
    parameter int          DATA_WIDTH     = 32,
    parameter int          ALU_OP_WIDTH   = 4,
    parameter logic [6:0]  BRANCH_OPCODE  = 7'b1100011
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      hold,
    input  logic                      id_valid,
    input  logic [6:0]                id_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic                      id_reg_wr_en,
    input  logic                      id_mem_rd_en,
    input  logic                      id_mem_wr_en,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic                      EX_MEM_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    output logic                      ID_EX_valid,
    output logic [6:0]                ID_EX_opcode,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2,
    output logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    output logic [DATA_WIDTH-1:0]     ID_EX_rs1_data,
    output logic [DATA_WIDTH-1:0]     ID_EX_rs2_data,
    output logic [DATA_WIDTH-1:0]     ID_EX_imm,
    output logic [DATA_WIDTH-1:0]     ID_EX_pc,
    output logic                      ID_EX_reg_wr_en,
    output logic                      ID_EX_mem_rd_en,
    output logic                      ID_EX_mem_wr_en,
    output logic [ALU_OP_WIDTH-1:0]   ID_EX_alu_op,
    output logic                      stall
);

    typedef enum logic {RUN, STALL} state_t;

    state_t state, state_nxt;
    logic   stall_cnt, stall_cnt_nxt;
    logic   uses_rs2, is_br, lu, bm, bl2;
    logic   upd_en, take_instr;

    always_comb begin
        uses_rs2 = (id_opcode == 7'b0110011) || (id_opcode == 7'b0100011) ||
                   (id_opcode == BRANCH_OPCODE);
        is_br    = (id_opcode == BRANCH_OPCODE);
        lu  = id_valid && ID_EX_mem_rd_en && (ID_EX_rd != '0) &&
              ((ID_EX_rd == id_rs1) || (uses_rs2 && (ID_EX_rd == id_rs2)));
        bm  = id_valid && is_br && EX_MEM_mem_rd_en && (EX_MEM_rd != '0) &&
              ((EX_MEM_rd == id_rs1) || (EX_MEM_rd == id_rs2));
        bl2 = is_br && lu;
    end

    always_comb begin
        state_nxt     = state;
        stall_cnt_nxt = stall_cnt;
        stall         = 1'b0;
        if (flush) begin
            state_nxt     = RUN;
            stall_cnt_nxt = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    stall = lu || bm;
                    if (bl2) begin
                        state_nxt     = STALL;
                        stall_cnt_nxt = 1'b1;
                    end
                end
                STALL: begin
                    // Hazard inputs are ignored here; the second bubble always follows.
                    stall         = 1'b1;
                    stall_cnt_nxt = 1'b0;
                    state_nxt     = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign upd_en     = flush || !hold;
    assign take_instr = !flush && !stall && id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            stall_cnt       <= 1'b0;
            ID_EX_valid     <= 1'b0;
            ID_EX_opcode    <= '0;
            ID_EX_rs1       <= '0;
            ID_EX_rs2       <= '0;
            ID_EX_rd        <= '0;
            ID_EX_rs1_data  <= '0;
            ID_EX_rs2_data  <= '0;
            ID_EX_imm       <= '0;
            ID_EX_pc        <= '0;
            ID_EX_reg_wr_en <= 1'b0;
            ID_EX_mem_rd_en <= 1'b0;
            ID_EX_mem_wr_en <= 1'b0;
            ID_EX_alu_op    <= '0;
        end else if (upd_en) begin
            state           <= state_nxt;
            stall_cnt       <= stall_cnt_nxt;
            ID_EX_valid     <= take_instr;
            ID_EX_opcode    <= take_instr ? id_opcode    : '0;
            ID_EX_rs1       <= take_instr ? id_rs1       : '0;
            ID_EX_rs2       <= take_instr ? id_rs2       : '0;
            ID_EX_rd        <= take_instr ? id_rd        : '0;
            ID_EX_rs1_data  <= take_instr ? id_rs1_data  : '0;
            ID_EX_rs2_data  <= take_instr ? id_rs2_data  : '0;
            ID_EX_imm       <= take_instr ? id_imm       : '0;
            ID_EX_pc        <= take_instr ? id_pc        : '0;
            ID_EX_reg_wr_en <= take_instr && id_reg_wr_en;
            ID_EX_mem_rd_en <= take_instr && id_mem_rd_en;
            ID_EX_mem_wr_en <= take_instr && id_mem_wr_en;
            ID_EX_alu_op    <= take_instr ? id_alu_op    : '0;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed pipeline scenarios with hand-computed results.
module tb_id_ex_hazard_reg;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        reg_wr_en;
        logic        mem_rd_en;
        logic        mem_wr_en;
        logic [3:0]  alu_op;
    } instr_t;

    typedef struct {
        logic   exp_stall;
        instr_t exp_regs;
        string  name;
    } item_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_ADDI= 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam int LOAD = 0, BUBBLE = 1, KEEP = 2;

    logic clk = 1'b0;
    logic rst_n, flush, hold;
    logic EX_MEM_mem_rd_en;
    logic [4:0] EX_MEM_rd;
    instr_t id_in, dut_out, exp_state;
    logic stall;

    logic ID_EX_valid, ID_EX_reg_wr_en, ID_EX_mem_rd_en, ID_EX_mem_wr_en;
    logic [6:0] ID_EX_opcode;
    logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc;
    logic [3:0] ID_EX_alu_op;

    item_t q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(32), .ALU_OP_WIDTH(4), .BRANCH_OPCODE(7'b1100011)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .id_valid(id_in.valid), .id_opcode(id_in.opcode),
        .id_rs1(id_in.rs1), .id_rs2(id_in.rs2), .id_rd(id_in.rd),
        .id_rs1_data(id_in.rs1_data), .id_rs2_data(id_in.rs2_data),
        .id_imm(id_in.imm), .id_pc(id_in.pc),
        .id_reg_wr_en(id_in.reg_wr_en), .id_mem_rd_en(id_in.mem_rd_en),
        .id_mem_wr_en(id_in.mem_wr_en), .id_alu_op(id_in.alu_op),
        .EX_MEM_mem_rd_en(EX_MEM_mem_rd_en), .EX_MEM_rd(EX_MEM_rd),
        .ID_EX_valid(ID_EX_valid), .ID_EX_opcode(ID_EX_opcode),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imm(ID_EX_imm), .ID_EX_pc(ID_EX_pc),
        .ID_EX_reg_wr_en(ID_EX_reg_wr_en), .ID_EX_mem_rd_en(ID_EX_mem_rd_en),
        .ID_EX_mem_wr_en(ID_EX_mem_wr_en), .ID_EX_alu_op(ID_EX_alu_op),
        .stall(stall)
    );

    assign dut_out = {ID_EX_valid, ID_EX_opcode, ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
                      ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc,
                      ID_EX_reg_wr_en, ID_EX_mem_rd_en, ID_EX_mem_wr_en, ID_EX_alu_op};

    function automatic instr_t mk(input logic [6:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] pc);
        instr_t r;
        r.valid     = 1'b1;
        r.opcode    = op;
        r.rd        = rd;
        r.rs1       = rs1;
        r.rs2       = rs2;
        r.rs1_data  = 32'h0000_1000 + 32'(rs1);
        r.rs2_data  = 32'h0000_2000 + 32'(rs2);
        r.imm       = 32'hFFF0_0000 | pc;
        r.pc        = pc;
        r.reg_wr_en = (op == OP_LW) || (op == OP_ADD) || (op == OP_ADDI);
        r.mem_rd_en = (op == OP_LW);
        r.mem_wr_en = (op == 7'b0100011);
        r.alu_op    = pc[5:2] ^ op[3:0];
        return r;
    endfunction

    task automatic chk_regs(input string nm, input instr_t act, input instr_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s regs: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_stall(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s stall: got %b expected %b", nm, act, exp);
        end
    endtask

    // One cycle of stimulus: drive after negedge, queue what the next edge must produce.
    task automatic step(input string nm, input instr_t i, input logic exm_rd_en,
                        input logic [4:0] exm_rd, input logic fl, input logic hd,
                        input logic exp_stall, input int kind);
        item_t it;
        @(negedge clk);
        #1;
        id_in = i;
        EX_MEM_mem_rd_en = exm_rd_en;
        EX_MEM_rd = exm_rd;
        flush = fl;
        hold = hd;
        case (kind)
            LOAD:    exp_state = i.valid ? i : '0;
            BUBBLE:  exp_state = '0;
            default: exp_state = exp_state;
        endcase
        it.exp_stall = exp_stall;
        it.exp_regs  = exp_state;
        it.name      = nm;
        q.push_back(it);
    endtask

    // Monitor: compare the combinational stall before the edge, registers after it.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                it = q.pop_front();
                chk_stall(it.name, stall, it.exp_stall);
                @(posedge clk);
                #1;
                chk_regs(it.name, dut_out, it.exp_regs);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t lw5, lw0, lw7, add6, add1, add8a, add8b, beq50, beq15, addi1, nv;
        lw5   = mk(OP_LW,   5'd5, 5'd1, 5'd0, 32'h100);
        lw0   = mk(OP_LW,   5'd0, 5'd2, 5'd0, 32'h104);
        lw7   = mk(OP_LW,   5'd7, 5'd3, 5'd0, 32'h108);
        add6  = mk(OP_ADD,  5'd6, 5'd5, 5'd7, 32'h10C);
        add1  = mk(OP_ADD,  5'd1, 5'd0, 5'd0, 32'h110);
        add8a = mk(OP_ADD,  5'd8, 5'd1, 5'd2, 32'h114);
        add8b = mk(OP_ADD,  5'd8, 5'd7, 5'd2, 32'h118);
        beq50 = mk(OP_BEQ,  5'd0, 5'd5, 5'd0, 32'h11C);
        beq15 = mk(OP_BEQ,  5'd0, 5'd1, 5'd5, 32'h120);
        addi1 = mk(OP_ADDI, 5'd1, 5'd2, 5'd5, 32'h124);
        nv    = mk(OP_ADD,  5'd9, 5'd5, 5'd5, 32'h128);
        nv.valid = 1'b0;

        exp_state = '0;
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        EX_MEM_mem_rd_en = 1'b0; EX_MEM_rd = '0;
        id_in = '0;
        #2;
        chk_regs("reset", dut_out, '0);
        chk_stall("reset", stall, 1'b0);
        #1 rst_n = 1'b1;

        // load-use: single bubble
        step("lw5",        lw5,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("lu_add",     add6,  1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUBBLE);
        step("lu_add_go",  add6,  1'b1, 5'd5, 1'b0, 1'b0, 1'b0, LOAD);
        // load feeding branch: two bubbles
        step("lw5_b",      lw5,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("bl2_c1",     beq50, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1, BUBBLE);
        step("bl2_c2",     beq50, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, BUBBLE);
        step("bl2_c3",     beq50, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        // invalid ID with matching rs1: no hazard, bubble loaded
        step("lw5_c",      lw5,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("invalid",    nv,    1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        // load in MEM feeding branch: single bubble
        step("bm_c1",      beq15, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, BUBBLE);
        step("bm_c2",      beq15, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        // x0 and rs2-slot of I-type never hazard
        step("lw0",        lw0,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("x0_add",     add1,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("lw5_d",      lw5,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("addi_rs2",   addi1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        // flush during STALL
        step("lw5_e",      lw5,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("fl_c1",      beq50, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, BUBBLE);
        step("fl_flush",   beq50, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, BUBBLE);
        step("fl_after",   add6,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        // hold freezes everything, stall keeps its value
        step("lw7",        lw7,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("hold1",      add8a, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, KEEP);
        step("hold2",      add8a, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, KEEP);
        step("hold3",      add8a, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, KEEP);
        step("hold_lu",    add8b, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, KEEP);
        step("unhold_lu",  add8b, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUBBLE);
        step("unhold_go",  add8b, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        // async reset mid-STALL
        step("lw5_f",      lw5,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("rst_c1",     beq50, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BUBBLE);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_regs("async_rst", dut_out, '0);
        chk_stall("async_rst", stall, 1'b0);
        #1 rst_n = 1'b1;
        exp_state = '0;
        step("rst_resume", beq50, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);
        step("rst_next",   add6,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, LOAD);

        repeat (3) @(negedge clk);
        #5;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d items left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
